bin2bcd_seq: RTL and testbench
==============================

Name: bin2bcd_seq

Overview:
- Sequential binary-to-BCD converter that sits directly upstream of the 4-digit seven-segment display multiplexer.
- Takes a binary result from the calculator datapath and converts it with the iterative shift-add-3 (double-dabble) method.
- Holds stable Value[15:0] (four BCD nibbles, digit 3 at [15:12]) and Point[3:0] outputs for the display stage.
- Outputs change only on conversion completion, so the display never shows a partial result.

Parameters:
- IN_W, 16, width of binary input; legal range 14..16.
- POINT_MASK, 4'b0000, decimal-point pattern driven on Point for a valid result (bit n = 1 lights the dot of digit n).

Ports:
- clk  input  1  system clock
- rst  input  1  asynchronous, active-high reset
- start  input  1  request conversion of bin; sampled only in IDLE
- bin  input  IN_W  binary operand; captured on the accepted start cycle
- busy  output  1  high while a conversion is in progress (CONVERT and DONE states)
- done  output  1  one-cycle pulse; Value/Point/ovf updated on the same edge
- Value  output  16  BCD result to display, digit 0 at [3:0]
- Point  output  4  decimal-point pattern to display
- ovf  output  1  last conversion exceeded 9999
- neg  output  1  last result negative (NEG_EN only; tied 0 otherwise)

Behaviour:
- Reset, asynchronous: state=IDLE, busy=0, done=0, Value=16'h0000, Point=4'b0000, ovf=0, neg=0, iteration counter=0, working registers cleared.
- FSM: IDLE -> CONVERT -> DONE -> IDLE.
- IDLE:
  - start=1 at a clock edge captures the magnitude (= bin, zero-extended to 16) into the shift register.
  - Clears the 20-bit BCD accumulator and sets count=0.
  - Captures the overflow flag (magnitude > 9999).
  - Goes to CONVERT; busy=1 from the next cycle.
- CONVERT, one iteration per clock:
  - Each of the 5 BCD nibbles that is >= 5 gets +3.
  - Then {bcd, shift} shifts left by 1.
  - count increments; after iteration 16 (count==15 on entry), go to DONE.
- DONE:
  - If no overflow: Value = bcd[15:0], Point = POINT_MASK, ovf=0.
  - If overflow: Value = 16'hEEEE, Point = 4'b0000, ovf=1.
  - done=1 for exactly this one cycle; next state IDLE; busy drops to 0 with the IDLE entry.
- Latency: start sampled at edge N -> done high during the cycle after edge N+17; outputs valid from that edge.
- Throughput: one conversion per 18 cycles; a start held high re-triggers immediately on IDLE.
- start while busy=1: ignored, not queued. bin changes during conversion: no effect.
- Value, Point, ovf and neg hold their last values between conversions.
- Reset mid-conversion: abort, outputs return to reset values, no done pulse.
- Arithmetic: 5 BCD nibbles are needed internally because 65535 needs 5 digits. Any nonzero nibble 4 is covered by the >9999 overflow check.

Optional Feature:
- Macro: BIN2BCD_NEG_EN.
- Defined:
  - bin is two's complement. If bin[IN_W-1]=1, magnitude = -bin, computed in IN_W+1 bits.
  - On valid completion: neg=1 and Point = POINT_MASK | 4'b1000 (leftmost dot marks negative).
  - On overflow: neg=1, Point=4'b1000, Value=16'hEEEE.
  - -(2^(IN_W-1)) is treated as overflow.
- Undefined: bin is unsigned; neg is constant 0; no sign logic is synthesised.

Decomposition:
- Package bin2bcd_pkg: state encoding (IDLE, CONVERT, DONE); constants BCD_DIGITS=5, OUT_DIGITS=4, MAX_DEC=9999, OVF_PATTERN=16'hEEEE, NEG_DOT=4'b1000, ITERATIONS=16.
- Sub-module bcd_add3: combinational 4-bit "if >=5 add 3" correction, instantiated 5 times per iteration.

Test Plan:
- Reset, then start with bin=16'h04D2 (1234) -> busy=1 for 17 cycles, done pulse 18 cycles after start, Value=16'h1234, Point=0000, ovf=0.
- bin=0 -> Value=16'h0000, ovf=0; then bin=9999 (16'h270F) -> Value=16'h9999, ovf=0.
- bin=10000 (16'h2710) and bin=65535 -> Value=16'hEEEE, Point=0000, ovf=1.
- Convert 1234; pulse start with bin=5678 at cycle 5 of CONVERT -> ignored; Value=16'h1234, exactly one done pulse.
- Start with bin=4321, assert rst at CONVERT iteration 8 -> immediate Value=0, busy=0, no done; a fresh start with bin=42 -> Value=16'h0042.
- NEG_EN defined, bin=16'hFB2E (-1234) -> Value=16'h1234, Point=1000, neg=1; bin=16'h8000 -> Value=16'hEEEE, ovf=1, neg=1.

Source files
------------

// File: rtl/bin2bcd_pkg.sv
// Shared states and constants for the sequential binary-to-BCD converter.
// Optional signed input support is enabled with BIN2BCD_NEG_EN.
package bin2bcd_pkg;

  typedef enum logic [1:0] {
    IDLE,
    CONVERT,
    DONE
  } state_t;

  localparam int          BCD_DIGITS  = 5;
  localparam int          OUT_DIGITS  = 4;
  localparam int          ITERATIONS  = 16;
  localparam logic [15:0] MAX_DEC     = 16'd9999;
  localparam logic [15:0] OVF_PATTERN = 16'hEEEE;
  localparam logic [3:0]  NEG_DOT     = 4'b1000;

endpackage

// File: rtl/bin2bcd_seq_add3.sv
// Double-dabble digit correction: add 3 to a BCD nibble that is 5 or more.
// Used once per digit for every shift iteration.
module bcd_add3 (
  input  logic [3:0] d,
  output logic [3:0] q
);

  assign q = (d >= 4'd5) ? d + 4'd3 : d;

endmodule

// File: rtl/bin2bcd_seq.sv
// Iterative shift-add-3 binary-to-BCD converter feeding the 7-seg mux.
// Define BIN2BCD_NEG_EN to treat bin as two's complement.
module bin2bcd_seq
  import bin2bcd_pkg::*;
#(
  parameter int         IN_W       = 16,
  parameter logic [3:0] POINT_MASK = 4'b0000
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start,
  input  logic [IN_W-1:0] bin,
  output logic            busy,
  output logic            done,
  output logic [15:0]     Value,
  output logic [3:0]      Point,
  output logic            ovf,
  output logic            neg
);

  localparam logic [3:0] LAST = 4'(ITERATIONS - 1);
  localparam int         BW   = BCD_DIGITS * 4;

  state_t        state;
  logic [15:0]   shift;
  logic [BW-1:0] bcd;
  logic [BW-1:0] adj;
  logic [3:0]    count;
  logic          ovf_r;
  logic [15:0]   mag;
  logic          mag_ovf;
  logic [3:0]    sign_dot;
  logic [BW+15:0] nxt;

`ifdef BIN2BCD_NEG_EN
  logic          sign;
  logic          neg_r;
  logic [IN_W:0] sx;
  logic [IN_W:0] nx;

  assign sign = bin[IN_W-1];
  assign sx   = {bin[IN_W-1], bin};
  assign nx   = sign ? -sx : sx;
  assign mag  = 16'(nx);
  // most-negative input has no positive twin at this width
  assign mag_ovf = (mag > MAX_DEC) ||
                   (sign && (bin[IN_W-2:0] == '0));
  assign sign_dot = neg_r ? NEG_DOT : 4'b0000;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      neg_r <= 1'b0;
      neg   <= 1'b0;
    end else begin
      if (state == IDLE && start) neg_r <= sign;
      if (state == DONE) neg <= neg_r;
    end
  end
`else
  assign mag      = 16'(bin);
  assign mag_ovf  = mag > MAX_DEC;
  assign sign_dot = 4'b0000;
  assign neg      = 1'b0;
`endif

  for (genvar i = 0; i < BCD_DIGITS; i++) begin : g_add3
    bcd_add3 u_add3 (
      .d(bcd[4*i +: 4]),
      .q(adj[4*i +: 4])
    );
  end

  assign nxt = {adj, shift} << 1;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      busy  <= 1'b0;
      done  <= 1'b0;
      Value <= '0;
      Point <= '0;
      ovf   <= 1'b0;
      count <= '0;
      shift <= '0;
      bcd   <= '0;
      ovf_r <= 1'b0;
    end else begin
      done <= 1'b0;
      unique case (state)
        IDLE: begin
          if (start) begin
            shift <= mag;
            bcd   <= '0;
            count <= '0;
            ovf_r <= mag_ovf;
            busy  <= 1'b1;
            state <= CONVERT;
          end
        end
        CONVERT: begin
          bcd   <= nxt[BW+15:16];
          shift <= nxt[15:0];
          count <= count + 4'd1;
          if (count == LAST) state <= DONE;
        end
        DONE: begin
          done  <= 1'b1;
          busy  <= 1'b0;
          state <= IDLE;
          if (ovf_r) begin
            Value <= OVF_PATTERN;
            Point <= sign_dot;
            ovf   <= 1'b1;
          end else begin
            Value <= bcd[OUT_DIGITS*4-1:0];
            Point <= POINT_MASK | sign_dot;
            ovf   <= 1'b0;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_bin2bcd_seq.sv
// Directed self-checking bench for bin2bcd_seq with an output scoreboard.
// Signed cases run only when BIN2BCD_NEG_EN is defined.
module tb_bin2bcd_seq;

  typedef struct packed {
    logic [15:0] value;
    logic [3:0]  point;
    logic        ovf;
    logic        neg;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        start = 1'b0;
  logic [15:0] bin = '0;
  logic        busy, done, ovf, neg;
  logic [15:0] value;
  logic [3:0]  point;

  int checks = 0;
  int errors = 0;
  int done_cnt = 0;
  exp_t sb[$];

  bin2bcd_seq #(.IN_W(16), .POINT_MASK(4'b0000)) dut (
    .clk(clk), .rst(rst), .start(start), .bin(bin),
    .busy(busy), .done(done), .Value(value), .Point(point),
    .ovf(ovf), .neg(neg)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  always @(negedge clk) begin
    if (done === 1'b1) begin
      done_cnt++;
      if (sb.size() == 0) begin
        chk("unexpected_done", 32'd1, 32'd0);
      end else begin
        exp_t e;
        e = sb.pop_front();
        chk("value", 32'(value), 32'(e.value));
        chk("point", 32'(point), 32'(e.point));
        chk("ovf", 32'(ovf), 32'(e.ovf));
        chk("neg", 32'(neg), 32'(e.neg));
      end
    end
  end

  function automatic exp_t mk(input logic [15:0] v, input logic [3:0] p,
                              input logic o, input logic n);
    exp_t e;
    e.value = v; e.point = p; e.ovf = o; e.neg = n;
    return e;
  endfunction

  // poke > 0: pulse start with bin=5678 at that cycle of the conversion
  task automatic convert(input logic [15:0] b, input exp_t e,
                         input int poke);
    int lat;
    int bcnt;
    sb.push_back(e);
    @(negedge clk);
    start = 1'b1;
    bin   = b;
    @(negedge clk);
    start = 1'b0;
    lat  = 1;
    bcnt = 0;
    while (done !== 1'b1 && lat < 40) begin
      if (busy === 1'b1) bcnt++;
      if (lat == poke) begin
        start = 1'b1;
        bin   = 16'd5678;
      end else begin
        start = 1'b0;
      end
      @(negedge clk);
      lat++;
    end
    start = 1'b0;
    chk("latency", 32'(lat), 32'd18);
    chk("busy_cycles", 32'(bcnt), 32'd17);
    chk("busy_after_done", 32'(busy), 32'd0);
    @(negedge clk);
    chk("done_width", 32'(done), 32'd0);
  endtask

  initial begin
    int d0;
    rst = 1'b1;
    repeat (2) @(negedge clk);
    chk("rst_value", 32'(value), 32'h0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_flags", {28'd0, point}, 32'h0);
    chk("rst_ovf", 32'(ovf), 32'd0);
    rst = 1'b0;
    @(negedge clk);

    convert(16'h04D2, mk(16'h1234, 4'b0000, 1'b0, 1'b0), 0);
    convert(16'h0000, mk(16'h0000, 4'b0000, 1'b0, 1'b0), 0);
    convert(16'h270F, mk(16'h9999, 4'b0000, 1'b0, 1'b0), 0);
    convert(16'h2710, mk(16'hEEEE, 4'b0000, 1'b1, 1'b0), 0);
    convert(16'hFFFF, mk(16'hEEEE, 4'b0000, 1'b1, 1'b0), 0);
    convert(16'd5, mk(16'h0005, 4'b0000, 1'b0, 1'b0), 0);

    d0 = done_cnt;
    convert(16'h04D2, mk(16'h1234, 4'b0000, 1'b0, 1'b0), 5);
    repeat (25) @(negedge clk);
    chk("ignored_start_dones", 32'(done_cnt - d0), 32'd1);
    chk("ignored_start_value", 32'(value), 32'h1234);

    d0 = done_cnt;
    @(negedge clk);
    start = 1'b1;
    bin   = 16'd4321;
    @(negedge clk);
    start = 1'b0;
    repeat (8) @(negedge clk);
    #2 rst = 1'b1;
    #1;
    chk("abort_value", 32'(value), 32'h0);
    chk("abort_busy", 32'(busy), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    repeat (25) @(negedge clk);
    chk("abort_no_done", 32'(done_cnt - d0), 32'd0);
    convert(16'd42, mk(16'h0042, 4'b0000, 1'b0, 1'b0), 0);

`ifdef BIN2BCD_NEG_EN
    convert(16'hFB2E, mk(16'h1234, 4'b1000, 1'b0, 1'b1), 0);
    convert(16'h8000, mk(16'hEEEE, 4'b1000, 1'b1, 1'b1), 0);
    convert(16'h0007, mk(16'h0007, 4'b0000, 1'b0, 1'b0), 0);
`endif

    repeat (3) @(negedge clk);
    chk("scoreboard_empty", 32'(sb.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

endmodule
